anton_neopixel_rx: RTL and testbench

ANTON_NEOPIXEL_RX -- requirements
Module: anton_neopixel_rx

---
 rtl/anton_neopixel_rx_pkg.sv | 19 +
 rtl/anton_neopixel_rx_assembler.sv | 81 ++++++++
 rtl/anton_neopixel_rx.sv | 157 +++++++++++++++
 tb/tb_anton_neopixel_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/anton_neopixel_rx_pkg.sv
// Shared NeoPixel definitions: receiver state encoding and default line timing
// at a 10 MHz sample clock, common to the transmitter and receiver.
package anton_neopixel_rx_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    IDLE      = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } rx_state_t;

  localparam int PIXEL_W             = 24;
  localparam int DEF_RESET_TICKS     = 500;
  localparam int DEF_T1_MIN          = 6;
  localparam int DEF_HIGH_MIN        = 2;
  localparam int DEF_HIGH_MAX        = 10;
  localparam int DEF_PIXELS_BITS     = 3;

endpackage

// File: rtl/anton_neopixel_rx_assembler.sv
// Collects decoded bits LSB-first into a 24-bit word and hands completed
// pixels to the consumer through a single holding register with valid/ready.
module anton_neopixel_rx_assembler
  import anton_neopixel_rx_pkg::*;
#(
  parameter int PIXELS_BITS = DEF_PIXELS_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_bit_vld,
  input  logic                   i_bit,
  input  logic                   i_discard,
  input  logic                   i_idx_clr,
  input  logic                   i_ready,
  output logic [PIXEL_W-1:0]     o_data,
  output logic                   o_valid,
  output logic [PIXELS_BITS-1:0] o_index,
  output logic                   o_overflow,
  output logic                   o_partial
);

  logic [PIXEL_W-1:0]     r_shift;
  logic [4:0]             r_bitcnt;
  logic [PIXEL_W-1:0]     r_hold;
  logic                   r_valid;
  logic [PIXELS_BITS-1:0] r_hold_idx;
  logic [PIXELS_BITS-1:0] r_pix_idx;
  logic                   r_ovf;
  logic                   w_complete;
  logic                   w_free;

  assign w_complete = i_bit_vld && (r_bitcnt == 5'd23);
  assign w_free     = !r_valid || i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_hold     <= '0;
      r_valid    <= 1'b0;
      r_hold_idx <= '0;
      r_pix_idx  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (w_complete) begin
        r_shift   <= '0;
        r_bitcnt  <= '0;
        // A dropped pixel still occupies its slot in the frame
        r_pix_idx <= r_pix_idx + 1'b1;
        if (w_free) begin
          r_hold     <= {i_bit, r_shift[PIXEL_W-1:1]};
          r_hold_idx <= r_pix_idx;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (i_bit_vld) begin
        r_shift  <= {i_bit, r_shift[PIXEL_W-1:1]};
        r_bitcnt <= r_bitcnt + 5'd1;
      end else if (i_discard) begin
        r_shift  <= '0;
        r_bitcnt <= '0;
      end
      if (i_idx_clr) begin
        r_pix_idx <= '0;
      end
      if (w_complete && w_free) begin
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data     = r_hold;
  assign o_valid    = r_valid;
  assign o_index    = r_hold_idx;
  assign o_overflow = r_ovf;
  assign o_partial  = (r_bitcnt != 5'd0);

endmodule

// File: rtl/anton_neopixel_rx.sv
// NeoPixel serial receiver: synchronizes the line, measures high/low times,
// decodes bits and frame gaps, and reports pulse-width and overflow errors.
module anton_neopixel_rx
  import anton_neopixel_rx_pkg::*;
#(
  parameter int RESET_TICKS = DEF_RESET_TICKS,
  parameter int T1_MIN      = DEF_T1_MIN,
  parameter int HIGH_MIN    = DEF_HIGH_MIN,
  parameter int HIGH_MAX    = DEF_HIGH_MAX,
  parameter int PIXELS_BITS = DEF_PIXELS_BITS
) (
  input  logic                   CLK_10MHZ,
  input  logic                   RESET,
  input  logic                   NEO_DATA,
  input  logic                   PIXEL_READY,
  output logic [PIXEL_W-1:0]     PIXEL_DATA,
  output logic                   PIXEL_VALID,
  output logic [PIXELS_BITS-1:0] PIXEL_INDEX,
  output logic                   FRAME_END,
  output logic                   ERR_CODE,
  output logic                   ERR_OVERFLOW
);

  localparam int WW = $clog2(HIGH_MAX + 2) + 1;
  localparam int LW = $clog2(RESET_TICKS + 1) + 1;

  logic            r_sync1, r_sync2, r_sync3;
  logic            w_rise, w_fall;
  rx_state_t       r_state, w_state_nxt;
  logic [WW-1:0]   r_width;
  logic [LW-1:0]   r_low;
  int              w_hlen;
  logic            w_width_clr, w_low_clr;
  logic            w_bit_vld, w_bit, w_discard, w_idx_clr;
  logic            w_frame_end, w_err, w_partial;
  logic            r_frame_end, r_err;

  assign w_rise = r_sync2 && !r_sync3;
  assign w_fall = !r_sync2 && r_sync3;
  // r_width excludes the rising-edge clock, so add it back for the true length
  assign w_hlen = int'(r_width) + 1;

  always_ff @(posedge CLK_10MHZ or posedge RESET) begin
    if (RESET) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_state     <= SYNC_WAIT;
      r_width     <= '0;
      r_low       <= '0;
      r_frame_end <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sync1     <= NEO_DATA;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_state     <= w_state_nxt;
      r_frame_end <= w_frame_end;
      r_err       <= w_err;
      if (w_width_clr) begin
        r_width <= '0;
      end else if (r_state == HIGH && r_sync2 && r_width != '1) begin
        r_width <= r_width + 1'b1;
      end
      if (w_low_clr) begin
        r_low <= '0;
      end else if (!r_sync2 && (r_state == SYNC_WAIT || r_state == LOW) && r_low != '1) begin
        r_low <= r_low + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_width_clr = 1'b0;
    w_low_clr   = 1'b0;
    w_bit_vld   = 1'b0;
    w_bit       = 1'b0;
    w_discard   = 1'b0;
    w_idx_clr   = 1'b0;
    w_frame_end = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      SYNC_WAIT: begin
        w_discard = 1'b1;
        w_idx_clr = 1'b1;
        if (r_sync2) begin
          w_low_clr = 1'b1;
        end else if (int'(r_low) + 1 >= RESET_TICKS) begin
          w_low_clr   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (w_rise) begin
          w_width_clr = 1'b1;
          w_state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (w_fall) begin
          if (w_hlen < HIGH_MIN || w_hlen > HIGH_MAX) begin
            w_err       = 1'b1;
            w_discard   = 1'b1;
            w_low_clr   = 1'b1;
            w_state_nxt = SYNC_WAIT;
          end else begin
            w_bit_vld   = 1'b1;
            w_bit       = (w_hlen >= T1_MIN);
            w_low_clr   = 1'b1;
            w_state_nxt = LOW;
          end
        end else if (w_hlen + 1 > HIGH_MAX) begin
          // Still high and already too long: abort without waiting for the fall
          w_err       = 1'b1;
          w_discard   = 1'b1;
          w_low_clr   = 1'b1;
          w_state_nxt = SYNC_WAIT;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_width_clr = 1'b1;
          w_state_nxt = HIGH;
        end else if (!r_sync2 && int'(r_low) + 1 >= RESET_TICKS) begin
          w_frame_end = 1'b1;
          w_err       = w_partial;
          w_discard   = 1'b1;
          w_idx_clr   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = SYNC_WAIT;
    endcase
  end

  anton_neopixel_rx_assembler #(
    .PIXELS_BITS (PIXELS_BITS)
  ) u_assembler (
    .i_clk      (CLK_10MHZ),
    .i_rst      (RESET),
    .i_bit_vld  (w_bit_vld),
    .i_bit      (w_bit),
    .i_discard  (w_discard),
    .i_idx_clr  (w_idx_clr),
    .i_ready    (PIXEL_READY),
    .o_data     (PIXEL_DATA),
    .o_valid    (PIXEL_VALID),
    .o_index    (PIXEL_INDEX),
    .o_overflow (ERR_OVERFLOW),
    .o_partial  (w_partial)
  );

  assign FRAME_END = r_frame_end;
  assign ERR_CODE  = r_err;

endmodule

// File: tb/tb_anton_neopixel_rx.sv
// Directed bench for the NeoPixel receiver: drives waveforms bit by bit and
// checks handshakes, pulses and reset behaviour against hand-derived values.
module tb_anton_neopixel_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        neo = 1'b0;
  logic        ready = 1'b1;
  logic [23:0] pdata;
  logic        pvalid;
  logic [2:0]  pindex;
  logic        frame_end, err_code, err_ovf;

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  int          fall_cyc = 0;
  int          fe_cyc = 0;
  int          hs_n = 0;
  logic [23:0] hs_data [16];
  logic [2:0]  hs_idx  [16];
  int          n_fe = 0, n_err = 0, n_ovf = 0, n_vld = 0;

  anton_neopixel_rx dut (
    .CLK_10MHZ    (clk),
    .RESET        (rst),
    .NEO_DATA     (neo),
    .PIXEL_READY  (ready),
    .PIXEL_DATA   (pdata),
    .PIXEL_VALID  (pvalid),
    .PIXEL_INDEX  (pindex),
    .FRAME_END    (frame_end),
    .ERR_CODE     (err_code),
    .ERR_OVERFLOW (err_ovf)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (pvalid) n_vld = n_vld + 1;
    if (pvalid && ready && hs_n < 16) begin
      hs_data[hs_n] = pdata;
      hs_idx[hs_n]  = pindex;
      hs_n = hs_n + 1;
    end
    if (frame_end) begin
      n_fe   = n_fe + 1;
      fe_cyc = cyc;
    end
    if (err_code) n_err = n_err + 1;
    if (err_ovf)  n_ovf = n_ovf + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_errors = n_errors + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    hs_n = 0; n_fe = 0; n_err = 0; n_ovf = 0; n_vld = 0;
  endtask

  task automatic send_bit(input logic b);
    neo = 1'b1;
    tick(b ? 8 : 3);
    neo = 1'b0;
    fall_cyc = cyc;
    tick(b ? 4 : 9);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    for (int i = 0; i < 24; i++) send_bit(p[i]);
  endtask

  logic [23:0] pix [5];

  initial begin
    pix[0] = 24'h000001; pix[1] = 24'h800000; pix[2] = 24'h123456;
    pix[3] = 24'hFFFFFF; pix[4] = 24'h0F0F0F;

    // Reset state
    rst = 1'b1;
    tick(3);
    check("rst_data",  32'(pdata), 32'h0);
    check("rst_valid", 32'(pvalid), 32'h0);
    check("rst_index", 32'(pindex), 32'h0);
    check("rst_fe",    32'(frame_end), 32'h0);
    check("rst_err",   32'(err_code), 32'h0);
    check("rst_ovf",   32'(err_ovf), 32'h0);
    rst = 1'b0;

    // Single pixel after the initial sync gap
    tick(600);
    check("sync_no_fe", 32'(n_fe), 32'h0);
    clear_counts();
    send_pixel(24'h0000A5);
    tick(5);
    check("a5_hs_count", 32'(hs_n), 32'd1);
    check("a5_data",     32'(hs_data[0]), 32'h0000A5);
    check("a5_index",    32'(hs_idx[0]), 32'h0);
    check("a5_vld_cyc",  32'(n_vld), 32'd1);
    check("a5_err",      32'(n_err), 32'h0);
    tick(600);
    check("a5_fe", 32'(n_fe), 32'd1);

    // Five pixels then a frame gap
    clear_counts();
    for (int k = 0; k < 5; k++) send_pixel(pix[k]);
    tick(600);
    check("five_hs_count", 32'(hs_n), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("five_data%0d", k), 32'(hs_data[k]), 32'(pix[k]));
      check($sformatf("five_idx%0d", k),  32'(hs_idx[k]), 32'(k));
    end
    check("five_fe", 32'(n_fe), 32'd1);
    check("five_fe_gap", 32'((fe_cyc - fall_cyc >= 500) && (fe_cyc - fall_cyc <= 510)), 32'd1);
    check("five_err", 32'(n_err), 32'h0);

    // Overflow: consumer stalled across two pixels
    clear_counts();
    ready = 1'b0;
    send_pixel(24'h654321);
    send_pixel(24'hABCDEF);
    tick(5);
    check("ovf_valid", 32'(pvalid), 32'd1);
    check("ovf_data",  32'(pdata), 32'h654321);
    check("ovf_index", 32'(pindex), 32'h0);
    check("ovf_pulse", 32'(n_ovf), 32'd1);
    ready = 1'b1;
    tick(3);
    check("ovf_hs_count", 32'(hs_n), 32'd1);
    check("ovf_hs_data",  32'(hs_data[0]), 32'h654321);
    check("ovf_valid_drop", 32'(pvalid), 32'h0);
    tick(600);

    // Glitch inside a frame, then resync and a clean pixel
    clear_counts();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    neo = 1'b1;
    tick(1);
    neo = 1'b0;
    tick(9);
    check("glitch_err", 32'(n_err), 32'd1);
    send_pixel(24'hFFFF00);
    tick(20);
    check("glitch_no_vld", 32'(n_vld), 32'h0);
    tick(600);
    check("glitch_no_fe", 32'(n_fe), 32'h0);
    send_pixel(24'h5A5A5A);
    tick(5);
    check("glitch_hs_count", 32'(hs_n), 32'd1);
    check("glitch_data",  32'(hs_data[0]), 32'h5A5A5A);
    check("glitch_index", 32'(hs_idx[0]), 32'h0);
    tick(600);

    // Partial pixel ended by a frame gap
    clear_counts();
    for (int i = 0; i < 12; i++) send_bit(i[0]);
    tick(600);
    check("partial_fe",  32'(n_fe), 32'd1);
    check("partial_err", 32'(n_err), 32'd1);
    check("partial_vld", 32'(n_vld), 32'h0);

    // Reset during bit 10 of pixel 2
    send_pixel(24'h00FF00);
    tick(5);
    clear_counts();
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    neo = 1'b1;
    tick(2);
    rst = 1'b1;
    #1;
    check("mid_rst_data",  32'(pdata), 32'h0);
    check("mid_rst_valid", 32'(pvalid), 32'h0);
    check("mid_rst_fe",    32'(frame_end), 32'h0);
    check("mid_rst_err",   32'(err_code), 32'h0);
    neo = 1'b0;
    tick(3);
    rst = 1'b0;
    send_pixel(24'h777777);
    tick(20);
    check("post_rst_no_vld", 32'(n_vld), 32'h0);
    check("post_rst_no_err", 32'(n_err), 32'h0);
    tick(600);
    check("post_rst_no_fe", 32'(n_fe), 32'h0);
    send_pixel(24'hC30F81);
    tick(5);
    check("post_rst_hs_count", 32'(hs_n), 32'd1);
    check("post_rst_data",  32'(hs_data[0]), 32'hC30F81);
    check("post_rst_index", 32'(hs_idx[0]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
